// File: rtl/vdg_timing_pkg.sv
// Shared constants and types for the 6847-replacement raster timing block.
// Vertical geometry is a function of the format latched at frame start.
package vdg_timing_pkg;

   typedef enum logic {FMT_PAL = 1'b0, FMT_NTSC = 1'b1} fmt_e;

   localparam logic [8:0] V_TOTAL_NTSC     = 9'd262;
   localparam logic [8:0] V_TOTAL_PAL      = 9'd312;
   localparam logic [8:0] V_ACT_START_NTSC = 9'd41;
   localparam logic [8:0] V_ACT_START_PAL  = 9'd64;

   typedef enum logic [1:0] {IDLE, PRE, FETCH} fetch_state_e;

   function automatic logic [8:0] v_total(input logic fmt);
      return (fmt == FMT_NTSC) ? V_TOTAL_NTSC : V_TOTAL_PAL;
   endfunction

   function automatic logic [8:0] v_active_start(input logic fmt);
      return (fmt == FMT_NTSC) ? V_ACT_START_NTSC : V_ACT_START_PAL;
   endfunction

endpackage

// File: rtl/vdg_fetch_seq.sv
// Byte-fetch sequencer: issues Load strobes across the fetch window and tracks
// the fetch address LSB and byte column. Decodes from next-cycle counts.
module vdg_fetch_seq
   import vdg_timing_pkg::*;
#(
   parameter int F0          = 121,
   parameter int ACTIVE_COLS = 256,
   parameter int FETCH_DIV   = 8
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [8:0] hcount_next,
   input  logic       line_start_next,
   input  logic       vactive_next,
   output logic       Load,
   output logic       DA0,
   output logic [4:0] ByteCol
);

   localparam logic [8:0] F_START = 9'(F0);
   localparam logic [8:0] F_END   = 9'(F0 + ACTIVE_COLS);
   localparam logic [8:0] PH_MASK = 9'(FETCH_DIV - 1);

   fetch_state_e state, state_next;
   logic         in_win, load_next;
   logic [8:0]   rel;

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (vactive_next && hcount_next == F_START) state_next = PRE;
         PRE:     if (Load) state_next = FETCH;
         FETCH:   if (hcount_next == F_END) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      rel       = hcount_next - F_START;
      in_win    = vactive_next && hcount_next >= F_START && hcount_next < F_END;
      load_next = (state_next != IDLE) && in_win && ((rel & PH_MASK) == 9'd0);
   end

   // DA0/ByteCol already reflect the fetch being strobed in the Load cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Load    <= 1'b0;
         DA0     <= 1'b0;
         ByteCol <= 5'd0;
      end else begin
         Load <= load_next;
         if (line_start_next) begin
            DA0     <= 1'b0;
            ByteCol <= 5'd0;
         end else if (load_next) begin
            DA0 <= ~DA0;
            if (ByteCol != 5'd31) ByteCol <= ByteCol + 5'd1;
         end
      end
   end

endmodule

// File: rtl/vdg_raster_timing.sv
// Raster timing for NTSC/PAL frames: counters, sync, active window, char-row
// and field counters. Every output is registered from the next-count decode.
module vdg_raster_timing
   import vdg_timing_pkg::*;
#(
   parameter int H_TOTAL        = 459,
   parameter int H_SYNC_END     = 28,
   parameter int H_ACTIVE_START = 130,
   parameter int ACTIVE_COLS    = 256,
   parameter int PRELOAD        = 9,
   parameter int FETCH_DIV      = 8,
   parameter int V_SYNC_END     = 7,
   parameter int ACTIVE_ROWS    = 192,
   parameter int FIELD_W        = 6
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Format,
   input  logic [3:0]         RowsPerChar,
   output logic               FormatOut,
   output logic               HSn,
   output logic               FSn,
   output logic               Active,
   output logic               Load,
   output logic               DA0,
   output logic [4:0]         ByteCol,
   output logic [3:0]         CharRow,
   output logic               LineStart,
   output logic               FrameStart,
   output logic [FIELD_W-1:0] FieldCount
);

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] H_SYNC = 9'(H_SYNC_END);
   localparam logic [8:0] H_ACT0 = 9'(H_ACTIVE_START);
   localparam logic [8:0] H_ACT1 = 9'(H_ACTIVE_START + ACTIVE_COLS);
   localparam logic [8:0] V_SYNC = 9'(V_SYNC_END);
   localparam logic [8:0] V_ROWS = 9'(ACTIVE_ROWS);

   logic [8:0] hcount, vcount, hcount_next, vcount_next, v_act0, v_act0_next;
   logic       h_wrap, frame_wrap, fmt_next, vact_cur, vact_next;
   logic [3:0] row_h;

   always_comb begin
      h_wrap      = (hcount == H_LAST);
      frame_wrap  = h_wrap && (vcount == v_total(FormatOut) - 9'd1);
      hcount_next = h_wrap ? 9'd0 : hcount + 9'd1;
      vcount_next = vcount;
      if (h_wrap) vcount_next = frame_wrap ? 9'd0 : vcount + 9'd1;
      // A new frame's geometry applies from its very first cycle.
      fmt_next    = frame_wrap ? Format : FormatOut;
      v_act0      = v_active_start(FormatOut);
      v_act0_next = v_active_start(fmt_next);
      vact_cur    = vcount >= v_act0 && vcount < v_act0 + V_ROWS;
      vact_next   = vcount_next >= v_act0_next && vcount_next < v_act0_next + V_ROWS;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hcount     <= 9'd0;
         vcount     <= 9'd0;
         FormatOut  <= FMT_NTSC;
         row_h      <= 4'd12;
         FieldCount <= '0;
         CharRow    <= 4'd0;
         HSn        <= 1'b0;
         FSn        <= 1'b0;
         Active     <= 1'b0;
         LineStart  <= 1'b1;
         FrameStart <= 1'b1;
      end else begin
         hcount     <= hcount_next;
         vcount     <= vcount_next;
         HSn        <= hcount_next >= H_SYNC;
         FSn        <= vcount_next >= V_SYNC;
         Active     <= vact_next && hcount_next >= H_ACT0 && hcount_next < H_ACT1;
         LineStart  <= h_wrap;
         FrameStart <= frame_wrap;
         if (frame_wrap) begin
            FormatOut  <= Format;
            row_h      <= (RowsPerChar == 4'd0) ? 4'd1 : RowsPerChar;
            FieldCount <= FieldCount + FIELD_W'(1);
            CharRow    <= 4'd0;
         end else if (h_wrap && vact_cur) begin
            CharRow <= (CharRow >= row_h - 4'd1) ? 4'd0 : CharRow + 4'd1;
         end
      end
   end

   vdg_fetch_seq #(
      .F0          (H_ACTIVE_START - PRELOAD),
      .ACTIVE_COLS (ACTIVE_COLS),
      .FETCH_DIV   (FETCH_DIV)
   ) u_fetch (
      .Clk             (Clk),
      .Rst             (Rst),
      .hcount_next     (hcount_next),
      .line_start_next (h_wrap),
      .vactive_next    (vact_next),
      .Load            (Load),
      .DA0             (DA0),
      .ByteCol         (ByteCol)
   );

endmodule

// File: tb/tb_vdg_raster_timing.sv
// Bench: a default-geometry instance and a shortened-line instance run side by
// side against a frame-time reference model, plus phase table and line probes.
module tb_vdg_raster_timing;
   import vdg_timing_pkg::*;

   logic       Clk = 1'b0, Rst = 1'b1, Format = 1'b1;
   logic [3:0] RowsPerChar = 4'd12;
   always #5 Clk = ~Clk;

   logic fo0, hs0, fs0, ac0, ld0, d0_da, ls0, fst0;
   logic fo1, hs1, fs1, ac1, ld1, d1_da, ls1, fst1;
   logic [4:0] bc0, bc1;
   logic [3:0] cr0, cr1;
   logic [5:0] fc0;
   logic [0:0] fc1;

   vdg_raster_timing u_def (
      .Clk(Clk), .Rst(Rst), .Format(Format), .RowsPerChar(RowsPerChar),
      .FormatOut(fo0), .HSn(hs0), .FSn(fs0), .Active(ac0), .Load(ld0), .DA0(d0_da),
      .ByteCol(bc0), .CharRow(cr0), .LineStart(ls0), .FrameStart(fst0), .FieldCount(fc0));

   vdg_raster_timing #(
      .H_TOTAL(80), .H_SYNC_END(5), .H_ACTIVE_START(12), .ACTIVE_COLS(64),
      .PRELOAD(3), .FETCH_DIV(2), .FIELD_W(1)
   ) u_small (
      .Clk(Clk), .Rst(Rst), .Format(Format), .RowsPerChar(RowsPerChar),
      .FormatOut(fo1), .HSn(hs1), .FSn(fs1), .Active(ac1), .Load(ld1), .DA0(d1_da),
      .ByteCol(bc1), .CharRow(cr1), .LineStart(ls1), .FrameStart(fst1), .FieldCount(fc1));

   // ---------------- reference model: time within frame ----------------
   typedef struct { int ht; int hse; int has; int ac; int pl; int fd; int fw; } cfg_t;
   cfg_t cfg [2];
   int ft [2], mfmt [2], mrpc [2], mfld [2];

   function automatic int flen(input int c);
      return (mfmt[c] != 0 ? 262 : 312) * cfg[c].ht;
   endfunction

   always @(posedge Clk) begin
      for (int c = 0; c < 2; c++) begin
         if (Rst) begin
            ft[c] = 0; mfmt[c] = 1; mrpc[c] = 12; mfld[c] = 0;
         end else begin
            ft[c] = ft[c] + 1;
            if (ft[c] == flen(c)) begin
               ft[c]   = 0;
               mfmt[c] = int'(Format);
               mrpc[c] = (RowsPerChar == 4'd0) ? 1 : int'(RowsPerChar);
               mfld[c] = (mfld[c] + 1) % (1 << cfg[c].fw);
            end
         end
      end
   end

   function automatic logic [22:0] expect_vec(input int c);
      int hc, vc, vas, f0, n, nl, cr, dv;
      logic vact, act, ld;
      hc  = ft[c] % cfg[c].ht;
      vc  = ft[c] / cfg[c].ht;
      vas = (mfmt[c] != 0) ? 41 : 64;
      vact = vc >= vas && vc < vas + 192;
      f0  = cfg[c].has - cfg[c].pl;
      nl  = cfg[c].ac / cfg[c].fd;
      act = vact && hc >= cfg[c].has && hc < cfg[c].has + cfg[c].ac;
      ld  = vact && hc >= f0 && hc < f0 + cfg[c].ac && ((hc - f0) % cfg[c].fd) == 0;
      n   = (vact && hc >= f0) ? (hc - f0) / cfg[c].fd + 1 : 0;
      if (n > nl) n = nl;
      dv  = (vc - vas > 192) ? 192 : vc - vas;
      cr  = (vc < vas) ? 0 : dv % mrpc[c];
      return {1'(mfmt[c]), hc >= cfg[c].hse, vc >= 7, act, ld, 1'(n % 2),
              5'((n > 31) ? 31 : n), 4'(cr), hc == 0, ft[c] == 0, 6'(mfld[c])};
   endfunction

   // ---------------- checking ----------------
   int checks = 0, passes = 0, fails = 0;
   bit mon_en = 1'b1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else begin
         fails++;
         if (fails <= 20) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   logic [22:0] act_v0, act_v1;
   assign act_v0 = {fo0, hs0, fs0, ac0, ld0, d0_da, bc0, cr0, ls0, fst0, fc0};
   assign act_v1 = {fo1, hs1, fs1, ac1, ld1, d1_da, bc1, cr1, ls1, fst1, 5'd0, fc1};

   always @(negedge Clk) begin
      if (mon_en) begin
         check("model_default", 32'(act_v0), 32'(expect_vec(0)));
         check("model_small",   32'(act_v1), 32'(expect_vec(1)));
      end
   end

   // ---------------- stimulus ----------------
   logic       cur_fmt = 1'b1;
   logic [3:0] cur_rpc = 4'd12;

   // Inputs wander randomly mid-frame; only the value near frame end matters.
   task automatic step();
      if (Rst || ft[1] >= flen(1) - 3) begin
         Format = cur_fmt; RowsPerChar = cur_rpc;
      end else begin
         Format = 1'($urandom_range(0, 1)); RowsPerChar = 4'($urandom_range(0, 15));
      end
      @(posedge Clk);
      @(negedge Clk);
   endtask

   typedef struct { bit rst; int cycles; logic fmt; logic [3:0] rpc; logic exp_fmt; int exp_fld; } phase_t;
   phase_t ph [5];
   localparam logic [22:0] RESET_VEC = {1'b1, 5'b00000, 5'd0, 4'd0, 1'b1, 1'b1, 6'd0};

   initial begin
      int n, nld, first, last, afirst, alast, da_bad, bc_end;
      cfg[0] = '{459, 28, 130, 256, 9, 8, 6};
      cfg[1] = '{80, 5, 12, 64, 3, 2, 1};
      ph[0] = '{1'b1, 3,     1'b1, 4'd12, 1'b1, 0};
      ph[1] = '{1'b0, 8000,  1'b1, 4'd12, 1'b1, 0};   // ends at small-frame line 100
      ph[2] = '{1'b0, 13060, 1'b0, 4'd0,  1'b0, 1};   // next frame PAL, row height 1
      ph[3] = '{1'b0, 24960, 1'b1, 4'd3,  1'b1, 0};   // back to NTSC, field wraps
      ph[4] = '{1'b0, 6000,  1'b0, 4'd5,  1'b1, 0};   // mid-frame change, no effect
      for (int p = 0; p < 5; p++) begin
         Rst = ph[p].rst; cur_fmt = ph[p].fmt; cur_rpc = ph[p].rpc;
         for (int k = 0; k < ph[p].cycles; k++) step();
         check("phase_format", 32'(fo1), 32'(ph[p].exp_fmt));
         check("phase_field",  32'(fc1), 32'(ph[p].exp_fld));
      end

      // One full active line on the default instance.
      n = 0;
      while (ft[0] % 459 != 0 && n < 1000) begin step(); n++; end
      check("wait_line_start", 32'(n < 1000), 32'd1);
      nld = 0; first = -1; last = -1; afirst = -1; alast = -1; da_bad = 0; bc_end = 0;
      for (int h = 0; h < 459; h++) begin
         if (ld0) begin
            if (nld == 0) first = h;
            last = h;
            if (d0_da !== ((nld % 2) == 0)) da_bad++;
            nld++;
         end
         if (ac0) begin
            if (afirst < 0) afirst = h;
            alast = h;
         end
         if (h == 400) bc_end = int'(bc0);
         step();
      end
      check("load_count",   32'(nld),    32'd32);
      check("load_first",   32'(first),  32'd121);
      check("load_last",    32'(last),   32'd369);
      check("da0_sequence", 32'(da_bad), 32'd0);
      check("bytecol_end",  32'(bc_end), 32'd31);
      check("active_first", 32'(afirst), 32'd130);
      check("active_last",  32'(alast),  32'd385);

      // Reset in the middle of a fetch.
      n = 0;
      while (ft[0] % 459 != 200 && n < 1000) begin step(); n++; end
      check("wait_hcount_200", 32'(n < 1000), 32'd1);
      check("fsm_fetching", 32'(u_def.u_fetch.state), 32'(FETCH));
      Rst = 1'b1;
      step();
      check("reset_default", 32'(act_v0), 32'(RESET_VEC));
      check("reset_small",   32'(act_v1), 32'(RESET_VEC));
      check("fsm_idle",      32'(u_def.u_fetch.state), 32'(IDLE));
      Rst = 1'b0; cur_fmt = 1'b1; cur_rpc = 4'd12;
      for (int k = 0; k < 500; k++) step();

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
